// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and state encodings
package uart_pkg;

    localparam int          DEF_BAUD_DIV = 434;
    localparam logic [21:0] DEF_GAP_CLKS = 22'd2_000_000;

    typedef enum logic {
        IDLE,
        WAIT_LOW
    } asm_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver: synchronizer, bit timing, shift register, framing check
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       rdy_o,
    output logic       busy_o
);

    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

    logic [1:0]  sync_q;
    logic        prev_q,  prev_d;
    logic        busy_q,  busy_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [3:0]  bit_q,   bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        rdy_q,   rdy_d;
    logic        rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= prev_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rdy_q   <= rdy_d;
        end
    end

    // bit_q indexes the sample: 0 = start, 1..8 = data LSB first, 9 = stop
    always_comb begin
        prev_d  = rx_s;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rdy_d   = 1'b0;
        if (!busy_q) begin
            if (prev_q && !rx_s) begin
                busy_d = 1'b1;
                cnt_d  = HALF_M1;
                bit_d  = 4'd0;
            end
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = FULL_M1;
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd0) begin
                // a start bit that is high again at mid-bit was a glitch
                if (rx_s) begin
                    busy_d = 1'b0;
                end
            end else if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                rdy_d  = rx_s;
            end else begin
                shift_d = {rx_s, shift_q[7:1]};
            end
        end
    end

    assign data_o = shift_q;
    assign rdy_o  = rdy_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/uart_wrapper.sv
// rtl/uart_wrapper.sv - full-duplex UART: two-byte command assembler and response transmitter
module uart_wrapper
    import uart_pkg::*;
#(
    parameter int          BAUD_DIV = DEF_BAUD_DIV,
    parameter logic [21:0] GAP_CLKS = DEF_GAP_CLKS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done
);

    localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_busy;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (RX),
        .data_o (rx_data),
        .rdy_o  (rx_rdy),
        .busy_o (rx_busy)
    );

    asm_state_e  state_q,   state_d;
    logic [15:0] cmd_q,     cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic [21:0] gap_q,     gap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            gap_q     <= gap_d;
        end
    end

    // Clear is applied first so a same-cycle set overrides it
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        gap_d     = gap_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    cmd_d[15:8] = rx_data;
                    cmd_rdy_d   = 1'b0;
                    gap_d       = '0;
                    state_d     = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (rx_rdy) begin
                    cmd_d[7:0] = rx_data;
                    cmd_rdy_d  = 1'b1;
                    gap_d      = '0;
                    state_d    = IDLE;
                end else if (!rx_busy) begin
                    // a low byte already in flight suspends the timeout
                    if (gap_q >= GAP_CLKS) begin
                        gap_d   = '0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + 22'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    tx_state_e   tx_state_q, tx_state_d;
    logic        tx_q,       tx_d;
    logic        tx_done_q,  tx_done_d;
    logic [8:0]  tx_shift_q, tx_shift_d;
    logic [15:0] tx_cnt_q,   tx_cnt_d;
    logic [3:0]  tx_bit_q,   tx_bit_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    // tx_shift_q holds the bits still to go out: data LSB first, then stop
    always_comb begin
        tx_state_d = tx_state_q;
        tx_d       = tx_q;
        tx_done_d  = tx_done_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (trmt) begin
                    tx_state_d = TX_SHIFT;
                    tx_d       = 1'b0;
                    tx_done_d  = 1'b0;
                    tx_shift_d = {1'b1, resp};
                    tx_cnt_d   = FULL_M1;
                    tx_bit_d   = 4'd0;
                end
            end
            TX_SHIFT: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (tx_bit_q == 4'd9) begin
                    tx_state_d = TX_IDLE;
                    tx_d       = 1'b1;
                    tx_done_d  = 1'b1;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                    tx_cnt_d   = FULL_M1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign TX      = tx_q;
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// tb/tb_uart_wrapper.sv - scoreboard bench for uart_wrapper
module tb_uart_wrapper;

    localparam int          B   = 434;
    localparam logic [21:0] GAP = 22'd3000;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        trmt;
    logic [7:0]  resp;
    logic        tx_done;

    uart_wrapper #(.BAUD_DIV(B), .GAP_CLKS(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .trmt        (trmt),
        .resp        (resp),
        .tx_done     (tx_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rst_gen = 0;
    int last_start = 0;
    int rise_cyc = 0;
    int wk;

    logic [15:0] exp_cmd[$];
    logic [7:0]  exp_tx[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_gen = rst_gen + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        RX = 1'b0;
        last_start = cyc;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = stop;
        repeat (B) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic pulse_trmt();
        @(negedge clk);
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
    endtask

    // command monitor: every rising cmd_rdy consumes one expected command
    initial begin : cmd_mon
        logic rdy_prev;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_rdy && !rdy_prev) begin
                rise_cyc = cyc;
                if (exp_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected: got %0h expected none", cmd);
                end else begin
                    check("cmd_value", 32'(cmd), 32'(exp_cmd.pop_front()));
                end
            end
            rdy_prev = cmd_rdy;
        end
    end

    // remote receiver on TX: decodes frames and times tx_done
    initial begin : tx_mon
        logic       tx_prev;
        logic [7:0] d;
        logic       stop;
        int         g, c0, k;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && tx_prev && !TX) begin
                g  = rst_gen;
                c0 = cyc;
                check("tx_done_low_at_start", 32'(tx_done), 32'd0);
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    d[i] = TX;
                end
                repeat (B) @(negedge clk);
                stop = TX;
                k = 0;
                while (!tx_done && k < B && rst_gen == g) begin
                    @(negedge clk);
                    k++;
                end
                if (rst_gen == g) begin
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %0h expected none", d);
                    end else begin
                        check("tx_byte", 32'(d), 32'(exp_tx.pop_front()));
                    end
                    check("tx_stop_bit", 32'(stop), 32'd1);
                    check("tx_done_latency", 32'(cyc - c0), 32'(10 * B));
                end
            end
            tx_prev = TX;
        end
    end

    initial begin : watchdog
        repeat (98000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n       = 1'b0;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        trmt        = 1'b0;
        resp        = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_cmd", 32'(cmd), 32'h0000);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // zero command, ready latency, clear
        exp_cmd.push_back(16'h0000);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("t030_rdy", 32'(cmd_rdy), 32'd1);
        check("t030_latency_window",
              32'((rise_cyc - last_start >= 9 * B + B / 2) && (rise_cyc - last_start <= 9 * B + B / 2 + 5)),
              32'd1);
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("t030_clr", 32'(cmd_rdy), 32'd0);

        // command 0x4022, then response 0xA5 sent while more bytes arrive
        exp_cmd.push_back(16'h4022);
        send_byte(8'h40, 1'b1);
        send_byte(8'h22, 1'b1);
        check("t031_cmd", 32'(cmd), 32'h4022);
        check("t031_rdy", 32'(cmd_rdy), 32'd1);
        resp = 8'hA5;
        exp_tx.push_back(8'hA5);
        pulse_trmt();

        // framing error ignored, then 0x1234
        send_byte(8'h55, 1'b0);
        repeat (2 * B) @(negedge clk);
        check("t033_bad_cmd_kept", 32'(cmd), 32'h4022);
        check("t033_bad_rdy_kept", 32'(cmd_rdy), 32'd1);
        send_byte(8'h12, 1'b1);
        check("t033_hi_drops_rdy", 32'(cmd_rdy), 32'd0);
        check("t033_hi_byte", 32'(cmd[15:8]), 32'h12);
        exp_cmd.push_back(16'h1234);
        send_byte(8'h34, 1'b1);
        check("t033_cmd", 32'(cmd), 32'h1234);
        check("t031_tx_done_level", 32'(tx_done), 32'd1);

        // gap timeout
        send_byte(8'h2F, 1'b1);
        check("t032_hi_rdy", 32'(cmd_rdy), 32'd0);
        repeat (int'(GAP) + 10) @(negedge clk);
        check("t032_hi_kept", 32'(cmd[15:8]), 32'h2F);
        check("t032_rdy_low", 32'(cmd_rdy), 32'd0);
        exp_cmd.push_back(16'h1122);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("t032_cmd", 32'(cmd), 32'h1122);

        // set beats a coincident clear
        exp_cmd.push_back(16'h7788);
        send_byte(8'h77, 1'b1);
        fork
            send_byte(8'h88, 1'b1);
            begin
                wk = 0;
                while (dut.rx_rdy !== 1'b1 && wk < 12 * B) begin
                    @(negedge clk);
                    wk++;
                end
                if (wk >= 12 * B) begin
                    checks++;
                    errors++;
                    $display("FAIL t034_rx_rdy_wait: got timeout expected pulse");
                end else begin
                    clr_cmd_rdy = 1'b1;
                    @(negedge clk);
                    clr_cmd_rdy = 1'b0;
                end
            end
        join
        check("t034_set_wins", 32'(cmd_rdy), 32'd1);

        // trmt mid-frame ignored, resp change mid-frame harmless
        resp = 8'h3C;
        exp_tx.push_back(8'h3C);
        pulse_trmt();
        repeat (3 * B) @(negedge clk);
        resp = 8'hC3;
        pulse_trmt();
        wk = 0;
        while (!tx_done && wk < 12 * B) begin
            @(negedge clk);
            wk++;
        end
        check("t034_tx_done_seen", 32'(tx_done), 32'd1);
        repeat (2 * B) @(negedge clk);
        check("t034_single_frame", 32'(exp_tx.size()), 32'd0);
        check("t034_tx_idle", 32'(TX), 32'd1);

        // reset in the middle of an RX byte and a TX frame
        resp = 8'h5A;
        pulse_trmt();
        @(negedge clk);
        RX = 1'b0;
        repeat (3 * B) @(negedge clk);
        rst_n = 1'b0;
        RX    = 1'b1;
        exp_tx.delete();
        exp_cmd.delete();
        #1;
        check("t035_tx", 32'(TX), 32'd1);
        check("t035_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("t035_cmd", 32'(cmd), 32'h0000);
        check("t035_tx_done", 32'(tx_done), 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_cmd.push_back(16'h4022);
        send_byte(8'h40, 1'b1);
        send_byte(8'h22, 1'b1);
        check("t035_cmd_after", 32'(cmd), 32'h4022);
        check("t035_rdy_after", 32'(cmd_rdy), 32'd1);

        repeat (10) @(negedge clk);
        check("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_wrapper.md
UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 Parameter BAUD_DIV, 434, clocks per UART bit (115200 baud at 50 MHz).
REQ-002 Parameter GAP_CLKS, 22'd2_000_000, max clocks allowed between high-byte stop and low-byte start.
REQ-003 clk  in  1  system clock; the only clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 RX  in  1  serial input from remote (8N1, LSB first, idle high), asynchronous to clk.
REQ-006 TX  out  1  serial output to remote (8N1, LSB first, idle high).
REQ-007 cmd  out  16  assembled command, high byte received first.
REQ-008 cmd_rdy  out  1  level, high while a complete unconsumed cmd is held.
REQ-009 clr_cmd_rdy  in  1  single-cycle pulse from consumer, command taken.
REQ-010 trmt  in  1  single-cycle pulse, start transmitting resp.
REQ-011 resp  in  8  response byte, sampled on trmt.
REQ-012 tx_done  out  1  level, high after a response frame completes, until next accepted trmt.

Function
REQ-013 RX shall pass through a 2-flop synchronizer, preset to 1, before any use.
REQ-014 RX framing: falling edge on synchronized RX starts a frame; bit sampled at BAUD_DIV/2 after edge, then every BAUD_DIV clocks; 8 data bits then stop bit.
REQ-015 Stop bit sampled 0 shall discard the byte (framing error) with no state change in the assembler.
REQ-016 Assembler FSM states: IDLE (expect high byte), WAIT_LOW (expect low byte).
REQ-017 IDLE + byte received: cmd[15:8] <= byte, cmd_rdy <= 0, go WAIT_LOW.
REQ-018 WAIT_LOW + byte received: cmd[7:0] <= byte, cmd_rdy <= 1 on the next clock edge, go IDLE.
REQ-019 WAIT_LOW: gap counter counts from high-byte stop sample; reaching GAP_CLKS with no start edge shall return FSM to IDLE, cmd_rdy stays 0, cmd[15:8] kept.
REQ-020 clr_cmd_rdy shall clear cmd_rdy next edge; clr_cmd_rdy and set in same cycle: set wins.
REQ-021 cmd shall not change while cmd_rdy is high except cmd[15:8] on a new high byte (which also drops cmd_rdy).
REQ-022 trmt while TX idle: latch resp, TX low (start bit) on next edge, tx_done <= 0; frame = start, 8 data LSB first, stop, each BAUD_DIV clocks.
REQ-023 tx_done shall rise on the edge ending the stop bit (10*BAUD_DIV clocks after TX fell); TX then idle high.
REQ-024 trmt while a frame is in progress shall be ignored; resp changes mid-frame shall not affect TX.
REQ-025 RX and TX paths shall operate fully concurrently (full duplex).

Reset
REQ-026 On rst_n low: TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0, FSM=IDLE, synchronizer=1, all counters 0.
REQ-027 Reset mid-frame shall abort both directions; after release RX waits for a fresh falling edge.

Structure
REQ-028 Shared package uart_pkg: BAUD_DIV default, GAP_CLKS default, assembler state enum (IDLE, WAIT_LOW), TX state enum (TX_IDLE, TX_SHIFT).
REQ-029 One sub-module uart_rx (synchronizer, bit timing, shift, rdy pulse, framing check); TX serializer and assembler FSM stay in uart_wrapper.

Verification
REQ-030 Remote sends 0x00 then 0x00 -> cmd_rdy rises within 2 clocks of low-byte stop sample, cmd=16'h0000; pulse clr_cmd_rdy -> cmd_rdy=0 next edge.
REQ-031 Remote sends 0x40, 0x22 -> cmd=16'h4022, cmd_rdy=1; trmt with resp=8'hA5 -> remote receives 0xA5, tx_done rises exactly 10*434 clocks after TX falls.
REQ-032 Send 0x2F, wait GAP_CLKS+10 clocks, send 0x11, 0x22 -> cmd=16'h1122, cmd_rdy pulses only once.
REQ-033 Frame 0x55 with stop bit forced 0, then 0x12, 0x34 -> cmd=16'h1234; bad byte ignored.
REQ-034 Assert clr_cmd_rdy on the same cycle cmd_rdy is set -> cmd_rdy=1; second trmt mid-frame -> single frame on TX.
REQ-035 Drop rst_n mid-RX-byte and mid-TX-frame -> TX=1, cmd_rdy=0, cmd=0 immediately; next full command 0x4022 received correctly.
